// File: rtl/pool_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pool_pkg
// Description : Shared types and sizes for the output-SRAM pooling reader.
// Revision    : 1.0  initial release
// ============================================================================
package pool_pkg;

    localparam int NUM_BANKS = 32;
    localparam int ADDR_W    = 12;
    localparam int DATA_W    = 32;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        MAX  = 2'd1,
        AVG  = 2'd2
    } pool_mode_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_ACC  = 3'd2,
        S_EMIT = 3'd3,
        S_DONE = 3'd4
    } pool_state_e;

    // Encoding 2'b11 is treated as no pooling.
    function automatic pool_mode_e decode_mode(input logic [1:0] sel);
        pool_mode_e m;
        case (sel)
            2'b01:   m = MAX;
            2'b10:   m = AVG;
            default: m = NONE;
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pool_alu.sv
`default_nettype none
// ============================================================================
// Module      : pool_alu
// Description : Combinational accumulator step (seed / max / sum) and final
//               result extraction with the average divide-by-four.
// Revision    : 1.0  initial release
// ============================================================================
module pool_alu #(
    parameter int DATA_W = 32
) (
    input  pool_pkg::pool_mode_e        i_mode,
    input  logic                        i_seed,
    input  logic signed [DATA_W+1:0]    i_acc,
    input  logic signed [DATA_W-1:0]    i_word,
    output logic signed [DATA_W+1:0]    o_acc_next,
    output logic        [DATA_W-1:0]    o_result
);
    import pool_pkg::*;

    logic signed [DATA_W+1:0] w_ext;
    logic signed [DATA_W+1:0] w_shift;

    always_comb begin
        w_ext      = {{2{i_word[DATA_W-1]}}, i_word};
        o_acc_next = w_ext;
        if (!i_seed) begin
            case (i_mode)
                MAX:     o_acc_next = (w_ext > i_acc) ? w_ext : i_acc;
                AVG:     o_acc_next = i_acc + w_ext;
                default: o_acc_next = w_ext;
            endcase
        end
        // Arithmetic shift floors toward minus infinity for negative sums.
        w_shift  = o_acc_next >>> 2;
        o_result = (i_mode == AVG) ? w_shift[DATA_W-1:0] : o_acc_next[DATA_W-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/pool_unit.sv
`default_nettype none
// ============================================================================
// Module      : pool_unit
// Description : Reads one feature map from a selected output SRAM bank,
//               applies optional 2x2 max/average pooling, streams results.
// Revision    : 1.0  initial release
// ============================================================================
module pool_unit #(
    parameter int NUM_BANKS = pool_pkg::NUM_BANKS,
    parameter int ADDR_W    = pool_pkg::ADDR_W,
    parameter int DATA_W    = pool_pkg::DATA_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [1:0]                    pooling,
    input  logic [6:0]                    map_size,
    input  logic [ADDR_W-1:0]             base_addr,
    input  logic [4:0]                    bank,
    output logic                          busy,
    output logic                          done,
    output logic [ADDR_W*NUM_BANKS-1:0]   output_SRAM_AB_pool,
    output logic                          output_SRAM_CEN_pool,
    output logic                          output_SRAM_OEN_pool,
    input  logic [DATA_W*NUM_BANKS-1:0]   output_SRAM_DO,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_W-1:0]             out_data
);
    import pool_pkg::*;

    pool_state_e              r_state;
    pool_state_e              w_next;
    pool_mode_e               r_mode;
    logic [ADDR_W-1:0]        r_base;
    logic [6:0]               r_size;
    logic [6:0]               r_dim;
    logic [6:0]               r_i;
    logic [6:0]               r_j;
    logic [4:0]               r_bank;
    logic [1:0]               r_k;
    logic signed [DATA_W+1:0] r_acc;
    logic [DATA_W-1:0]        r_out;

    logic                     w_pooled_in;
    logic [6:0]               w_dim_in;
    logic                     w_pooled;
    logic                     w_last_k;
    logic                     w_last_win;
    logic [6:0]               w_row;
    logic [6:0]               w_col;
    logic [13:0]              w_prod;
    logic [ADDR_W-1:0]        w_addr;
    logic                     w_seed;
    logic signed [DATA_W+1:0] w_acc_next;
    logic [DATA_W-1:0]        w_result;
    logic [NUM_BANKS-1:0][DATA_W-1:0] w_do;

    assign w_pooled_in = (pooling == 2'b01) || (pooling == 2'b10);
    assign w_dim_in    = w_pooled_in ? {1'b0, map_size[6:1]} : map_size;
    assign w_pooled    = (r_mode != NONE);
    assign w_last_k    = (r_k == (w_pooled ? 2'd3 : 2'd0));
    assign w_last_win  = (r_i == r_dim - 7'd1) && (r_j == r_dim - 7'd1);

    // Window pixel k: bit 1 selects the lower row, bit 0 the right column.
    assign w_row  = w_pooled ? ({r_i[5:0], 1'b0} | {6'b0, r_k[1]}) : r_i;
    assign w_col  = w_pooled ? ({r_j[5:0], 1'b0} | {6'b0, r_k[0]}) : r_j;
    assign w_prod = {7'b0, w_row} * {7'b0, r_size};
    assign w_addr = r_base + ADDR_W'(w_prod) + ADDR_W'(w_col);

    assign w_do   = output_SRAM_DO;
    assign w_seed = ((r_state == S_READ) && (r_k == 2'd1)) ||
                    ((r_state == S_ACC) && !w_pooled);

    pool_alu #(
        .DATA_W     (DATA_W)
    ) u_alu (
        .i_mode     (r_mode),
        .i_seed     (w_seed),
        .i_acc      (r_acc),
        .i_word     (w_do[r_bank]),
        .o_acc_next (w_acc_next),
        .o_result   (w_result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_next = (w_dim_in == 7'd0) ? S_DONE : S_READ;
            S_READ: if (w_last_k) w_next = S_ACC;
            S_ACC:  w_next = S_EMIT;
            S_EMIT: if (out_ready) w_next = w_last_win ? S_DONE : S_READ;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode <= NONE;
            r_base <= '0;
            r_size <= '0;
            r_dim  <= '0;
            r_i    <= '0;
            r_j    <= '0;
            r_bank <= '0;
            r_k    <= '0;
            r_acc  <= '0;
            r_out  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode <= decode_mode(pooling);
                        r_base <= base_addr;
                        r_size <= map_size;
                        r_dim  <= w_dim_in;
                        r_bank <= bank;
                        r_i    <= '0;
                        r_j    <= '0;
                        r_k    <= '0;
                    end
                end
                S_READ: begin
                    r_k <= w_last_k ? 2'd0 : r_k + 2'd1;
                    // Data returned now belongs to the address issued last cycle.
                    if (r_k != 2'd0) r_acc <= w_acc_next;
                end
                S_ACC: begin
                    r_acc <= w_acc_next;
                    r_out <= w_result;
                end
                S_EMIT: begin
                    if (out_ready && !w_last_win) begin
                        if (r_j == r_dim - 7'd1) begin
                            r_j <= '0;
                            r_i <= r_i + 7'd1;
                        end else begin
                            r_j <= r_j + 7'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign output_SRAM_AB_pool  = {NUM_BANKS{(r_state == S_READ) ? w_addr : {ADDR_W{1'b0}}}};
    assign output_SRAM_CEN_pool = (r_state != S_READ);
    assign output_SRAM_OEN_pool = (r_state != S_READ);
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign out_valid = (r_state == S_EMIT);
    assign out_data  = r_out;

endmodule
`default_nettype wire

// File: tb/tb_pool_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pool_unit
// Description : Directed self-checking bench for pool_unit with an SRAM model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pool_unit;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [1:0]         pooling = 2'b00;
    logic [6:0]         map_size = 7'd0;
    logic [11:0]        base_addr = 12'd0;
    logic [4:0]         bank = 5'd0;
    logic               busy, done;
    logic [31:0][11:0]  ab_pk;
    logic               cen, oen;
    logic [31:0][31:0]  do_pk;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [31:0]        out_data;

    logic [31:0]        mem [0:31][0:4095];
    logic signed [31:0] got[$];
    logic [11:0]        addrs[$];
    int                 total = 0;
    int                 bad = 0;
    int                 first_valid, done_cyc, last_hs, stall_cnt;
    bit                 timed_out, stall_data_bad, stall_cen_bad;

    always #5 clk = ~clk;

    pool_unit u_dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .pooling              (pooling),
        .map_size             (map_size),
        .base_addr            (base_addr),
        .bank                 (bank),
        .busy                 (busy),
        .done                 (done),
        .output_SRAM_AB_pool  (ab_pk),
        .output_SRAM_CEN_pool (cen),
        .output_SRAM_OEN_pool (oen),
        .output_SRAM_DO       (do_pk),
        .out_valid            (out_valid),
        .out_ready            (out_ready),
        .out_data             (out_data)
    );

    always @(posedge clk) begin
        if (!cen && !oen) begin
            for (int b = 0; b < 32; b++) do_pk[b] <= mem[b][ab_pk[b]];
            addrs.push_back(ab_pk[0]);
        end
    end

    task automatic run_op(input logic [1:0] p, input int sz, input int base, input int bk,
                          input int stall_at, input int stall_len, input int extra_at,
                          input int budget);
        int cyc;
        logic [31:0] held;
        got.delete();
        addrs.delete();
        first_valid = -1; done_cyc = -1; last_hs = -1; stall_cnt = 0;
        stall_data_bad = 0; stall_cen_bad = 0; held = '0;
        @(negedge clk);
        pooling = p; map_size = 7'(sz); base_addr = 12'(base); bank = 5'(bk);
        start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc <= budget) begin
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (cyc == extra_at) begin
                start = 1'b1; pooling = 2'b00; map_size = 7'd0;
            end else begin
                start = 1'b0;
            end
            if (out_valid && got.size() == stall_at && stall_cnt < stall_len) begin
                out_ready = 1'b0;
                if (stall_cnt == 0) held = out_data;
                else if (out_data !== held) stall_data_bad = 1;
                if (!cen) stall_cen_bad = 1;
                stall_cnt++;
            end else begin
                out_ready = 1'b1;
            end
            if (out_valid && out_ready) begin
                got.push_back(out_data);
                last_hs = cyc;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        out_ready = 1'b1;
        timed_out = (done_cyc < 0);
    endtask

    task automatic test_reset();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %0b expected 0", done); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b expected 0", out_valid); end
        total++; if (out_data !== 32'd0) begin bad++; $display("FAIL reset_data: got %0h expected 0", out_data); end
        total++; if (cen !== 1'b1 || oen !== 1'b1) begin bad++; $display("FAIL reset_cen_oen: got %0b%0b expected 11", cen, oen); end
        total++; if (ab_pk !== '0) begin bad++; $display("FAIL reset_ab: got %0h expected 0", ab_pk[0]); end
    endtask

    task automatic test_none();
        for (int k = 0; k < 9; k++) mem[5][12'h010 + k] = 32'(k);
        run_op(2'b00, 3, 12'h010, 5, -1, 0, -1, 200);
        total++; if (timed_out) begin bad++; $display("FAIL none_timeout: got no done expected done"); end
        total++; if (got.size() != 9) begin bad++; $display("FAIL none_count: got %0d expected 9", got.size()); end
        for (int k = 0; k < 9 && k < got.size(); k++) begin
            total++; if (got[k] !== 32'(k)) begin bad++; $display("FAIL none_data[%0d]: got %0d expected %0d", k, got[k], k); end
        end
        total++; if (addrs.size() != 9) begin bad++; $display("FAIL none_addr_count: got %0d expected 9", addrs.size()); end
        for (int k = 0; k < 9 && k < addrs.size(); k++) begin
            total++; if (addrs[k] !== 12'(16 + k)) begin bad++; $display("FAIL none_addr[%0d]: got %0h expected %0h", k, addrs[k], 16 + k); end
        end
        total++; if (first_valid != 3) begin bad++; $display("FAIL none_latency: got %0d expected 3", first_valid); end
        total++; if (done_cyc != 28 || last_hs != 27) begin bad++; $display("FAIL none_done_cycle: got %0d/%0d expected 28/27", done_cyc, last_hs); end
        @(negedge clk);
        total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL none_done_pulse: got done=%0b busy=%0b expected 0 0", done, busy); end
    endtask

    task automatic test_max();
        int v[16] = '{1, -2, 3, 4, 5, 6, -7, 8, 9, 10, 11, 12, 13, -14, 15, 16};
        int e[4]  = '{6, 8, 13, 16};
        for (int k = 0; k < 16; k++) mem[0][12'h100 + k] = 32'(v[k]);
        run_op(2'b01, 4, 12'h100, 0, -1, 0, -1, 200);
        total++; if (timed_out || got.size() != 4) begin bad++; $display("FAIL max_count: got %0d expected 4", got.size()); end
        for (int k = 0; k < 4 && k < got.size(); k++) begin
            total++; if (got[k] !== 32'(e[k])) begin bad++; $display("FAIL max_data[%0d]: got %0d expected %0d", k, got[k], e[k]); end
        end
        total++; if (first_valid != 6 || done_cyc != 25) begin bad++; $display("FAIL max_timing: got %0d/%0d expected 6/25", first_valid, done_cyc); end
    endtask

    task automatic test_avg();
        mem[3][12'hFFE] = -32'sd1; mem[3][12'hFFF] = -32'sd2;
        mem[3][12'h000] = -32'sd3; mem[3][12'h001] = -32'sd4;
        run_op(2'b10, 2, 12'hFFE, 3, -1, 0, -1, 100);
        total++; if (timed_out || got.size() != 1) begin bad++; $display("FAIL avg_neg_count: got %0d expected 1", got.size()); end
        else begin
            total++; if (got[0] !== -32'sd3) begin bad++; $display("FAIL avg_neg: got %0d expected -3", got[0]); end
        end
        total++; if (addrs.size() != 4 || addrs[0] !== 12'hFFE || addrs[2] !== 12'h000 || addrs[3] !== 12'h001) begin
            bad++; $display("FAIL avg_wrap_addr: got %0d addresses expected FFE,FFF,000,001", addrs.size());
        end
        mem[3][12'h020] = 32'd1; mem[3][12'h021] = 32'd1;
        mem[3][12'h022] = 32'd1; mem[3][12'h023] = 32'd2;
        run_op(2'b10, 2, 12'h020, 3, -1, 0, -1, 100);
        total++; if (timed_out || got.size() != 1) begin bad++; $display("FAIL avg_pos_count: got %0d expected 1", got.size()); end
        else begin
            total++; if (got[0] !== 32'sd1) begin bad++; $display("FAIL avg_pos: got %0d expected 1", got[0]); end
        end
    endtask

    task automatic test_odd_and_zero();
        int e[4] = '{6, 8, 16, 18};
        int viol = 0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                mem[7][12'h200 + r*5 + c] = (r == 4 || c == 4) ? 32'd1000 : 32'(r*5 + c);
        run_op(2'b01, 5, 12'h200, 7, -1, 0, -1, 200);
        total++; if (timed_out || got.size() != 4) begin bad++; $display("FAIL odd_count: got %0d expected 4", got.size()); end
        for (int k = 0; k < 4 && k < got.size(); k++) begin
            total++; if (got[k] !== 32'(e[k])) begin bad++; $display("FAIL odd_data[%0d]: got %0d expected %0d", k, got[k], e[k]); end
        end
        foreach (addrs[k]) begin
            int off;
            off = int'(addrs[k]) - 'h200;
            if (off < 0 || off / 5 >= 4 || off % 5 >= 4) viol++;
        end
        total++; if (addrs.size() != 16 || viol != 0) begin bad++; $display("FAIL odd_addr: got %0d reads %0d outside expected 16 reads 0 outside", addrs.size(), viol); end
        run_op(2'b01, 1, 12'h000, 7, -1, 0, -1, 20);
        total++; if (done_cyc != 1 || addrs.size() != 0 || got.size() != 0) begin
            bad++; $display("FAIL size1_pooled: got done at %0d reads %0d outputs %0d expected 1 0 0", done_cyc, addrs.size(), got.size());
        end
        run_op(2'b00, 0, 12'h000, 7, -1, 0, -1, 20);
        total++; if (done_cyc != 1 || addrs.size() != 0) begin
            bad++; $display("FAIL size0: got done at %0d reads %0d expected 1 0", done_cyc, addrs.size());
        end
    endtask

    task automatic test_stall();
        run_op(2'b00, 3, 12'h010, 5, 1, 7, -1, 200);
        total++; if (timed_out || got.size() != 9) begin bad++; $display("FAIL stall_count: got %0d expected 9", got.size()); end
        for (int k = 0; k < 9 && k < got.size(); k++) begin
            total++; if (got[k] !== 32'(k)) begin bad++; $display("FAIL stall_data[%0d]: got %0d expected %0d", k, got[k], k); end
        end
        total++; if (stall_cnt != 7 || stall_data_bad || stall_cen_bad) begin
            bad++; $display("FAIL stall_hold: got cycles=%0d data_moved=%0b cen_low=%0b expected 7 0 0", stall_cnt, stall_data_bad, stall_cen_bad);
        end
        total++; if (addrs.size() != 9 || done_cyc != 35) begin bad++; $display("FAIL stall_reads: got %0d reads done %0d expected 9 35", addrs.size(), done_cyc); end
    endtask

    task automatic test_reset_mid();
        int e[4] = '{6, 8, 13, 16};
        int spur = 0;
        @(negedge clk);
        pooling = 2'b01; map_size = 7'd4; base_addr = 12'h100; bank = 5'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 14; c++) @(negedge clk);
        total++; if (cen !== 1'b0 || out_data !== 32'd8) begin bad++; $display("FAIL mid_pre: got cen=%0b data=%0d expected 0 8", cen, out_data); end
        rst = 1'b1;
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (done || out_valid || !cen) spur++;
            @(negedge clk);
        end
        total++; if (spur != 0) begin bad++; $display("FAIL mid_spurious: got %0d active cycles expected 0", spur); end
        run_op(2'b01, 4, 12'h100, 0, -1, 0, 3, 200);
        total++; if (timed_out || got.size() != 4) begin bad++; $display("FAIL restart_count: got %0d expected 4", got.size()); end
        for (int k = 0; k < 4 && k < got.size(); k++) begin
            total++; if (got[k] !== 32'(e[k])) begin bad++; $display("FAIL restart_data[%0d]: got %0d expected %0d", k, got[k], e[k]); end
        end
        total++; if (done_cyc != 25) begin bad++; $display("FAIL restart_done: got %0d expected 25", done_cyc); end
    endtask

    initial begin
        for (int b = 0; b < 32; b++)
            for (int a = 0; a < 4096; a++)
                mem[b][a] = 32'h7000_0000 + 32'(b * 4096 + a);
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_none();
        test_max();
        test_avg();
        test_odd_and_zero();
        test_stall();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
